// File: rtl/iomem_arbiter.sv
// iomem_arbiter: shares the single iomem bus between the data and instruction ports.
// Data wins arbitration, but an instruction waits for at most DATA_PRIO_MAX data grants.
module iomem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DATA_PRIO_MAX  = 4
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        ins_req_i,
    input  logic [31:0] ins_addr_i,
    output logic        ins_gnt_o,
    output logic        ins_rvalid_o,
    output logic [31:0] ins_rdata_o,
    output logic        ins_err_o,
    input  logic        dat_req_i,
    input  logic [31:0] dat_addr_i,
    input  logic [3:0]  dat_wstrb_i,
    input  logic [31:0] dat_wdata_i,
    output logic        dat_gnt_o,
    output logic        dat_rvalid_o,
    output logic [31:0] dat_rdata_o,
    output logic        dat_err_o,
    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [3:0]  iomem_wstrb_o,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    input  logic [31:0] iomem_rdata_i,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | no transaction in flight; requests are arbitrated combinationally
    // BUSY  | iomem_valid_o high, waiting for iomem_ready_i or the timeout
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int STREAK_W = ($clog2(DATA_PRIO_MAX + 1) > 3) ? $clog2(DATA_PRIO_MAX + 1) : 3;
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_PRIO_MAX);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                owner_dat;
    logic                grant_dat;
    logic                grant_ins;
    logic                finish;
    logic [31:0]         resp_data;

    // Grants are gated by reset so a held request is never acknowledged during reset.
    always_comb begin
        grant_dat = 1'b0;
        grant_ins = 1'b0;
        if (rst_n && state == IDLE) begin
            if (dat_req_i && !(ins_req_i && streak == STREAK_MAX)) begin
                grant_dat = 1'b1;
            end else if (ins_req_i) begin
                grant_ins = 1'b1;
            end
        end
    end

    assign dat_gnt_o = grant_dat;
    assign ins_gnt_o = grant_ins;
    assign busy_o    = (state == BUSY);
    assign finish    = iomem_ready_i || (tmo_cnt == TMO_LAST);
    // Writes and timeouts return zero; ready takes precedence over a coincident timeout.
    assign resp_data = (iomem_ready_i && iomem_wstrb_o == 4'h0) ? iomem_rdata_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state         <= IDLE;
            streak        <= '0;
            tmo_cnt       <= '0;
            owner_dat     <= 1'b0;
            iomem_valid_o <= 1'b0;
            iomem_wstrb_o <= 4'h0;
            iomem_addr_o  <= 32'h0;
            iomem_wdata_o <= 32'h0;
            ins_rvalid_o  <= 1'b0;
            ins_err_o     <= 1'b0;
            ins_rdata_o   <= 32'h0;
            dat_rvalid_o  <= 1'b0;
            dat_err_o     <= 1'b0;
            dat_rdata_o   <= 32'h0;
        end else begin
            ins_rvalid_o <= 1'b0;
            ins_err_o    <= 1'b0;
            dat_rvalid_o <= 1'b0;
            dat_err_o    <= 1'b0;
            if (state == IDLE) begin
                if (grant_dat) begin
                    state         <= BUSY;
                    owner_dat     <= 1'b1;
                    tmo_cnt       <= '0;
                    iomem_valid_o <= 1'b1;
                    iomem_addr_o  <= dat_addr_i;
                    iomem_wstrb_o <= dat_wstrb_i;
                    iomem_wdata_o <= dat_wdata_i;
                    if (!ins_req_i) begin
                        streak <= '0;
                    end else if (streak != STREAK_MAX) begin
                        streak <= streak + STREAK_W'(1);
                    end
                end else if (grant_ins) begin
                    state         <= BUSY;
                    owner_dat     <= 1'b0;
                    tmo_cnt       <= '0;
                    iomem_valid_o <= 1'b1;
                    iomem_addr_o  <= ins_addr_i;
                    iomem_wstrb_o <= 4'h0;
                    iomem_wdata_o <= 32'h0;
                    streak        <= '0;
                end
            end else begin
                if (finish) begin
                    state         <= IDLE;
                    iomem_valid_o <= 1'b0;
                    if (owner_dat) begin
                        dat_rvalid_o <= 1'b1;
                        dat_err_o    <= !iomem_ready_i;
                        dat_rdata_o  <= resp_data;
                    end else begin
                        ins_rvalid_o <= 1'b1;
                        ins_err_o    <= !iomem_ready_i;
                        ins_rdata_o  <= resp_data;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb_iomem_arbiter: directed and randomized transactions against a transaction-level
// model of the arbiter plus a bench-side RAM/timer slave on the iomem bus.
module tb_iomem_arbiter;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int DATA_PRIO_MAX  = 4;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        ins_req_i;
    logic [31:0] ins_addr_i;
    logic        ins_gnt_o;
    logic        ins_rvalid_o;
    logic [31:0] ins_rdata_o;
    logic        ins_err_o;
    logic        dat_req_i;
    logic [31:0] dat_addr_i;
    logic [3:0]  dat_wstrb_i;
    logic [31:0] dat_wdata_i;
    logic        dat_gnt_o;
    logic        dat_rvalid_o;
    logic [31:0] dat_rdata_o;
    logic        dat_err_o;
    logic        iomem_valid_o;
    logic        iomem_ready_i;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_addr_o;
    logic [31:0] iomem_wdata_o;
    logic [31:0] iomem_rdata_i;
    logic        busy_o;

    iomem_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DATA_PRIO_MAX(DATA_PRIO_MAX)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .ins_req_i(ins_req_i), .ins_addr_i(ins_addr_i), .ins_gnt_o(ins_gnt_o),
        .ins_rvalid_o(ins_rvalid_o), .ins_rdata_o(ins_rdata_o), .ins_err_o(ins_err_o),
        .dat_req_i(dat_req_i), .dat_addr_i(dat_addr_i), .dat_wstrb_i(dat_wstrb_i),
        .dat_wdata_i(dat_wdata_i), .dat_gnt_o(dat_gnt_o), .dat_rvalid_o(dat_rvalid_o),
        .dat_rdata_o(dat_rdata_o), .dat_err_o(dat_err_o),
        .iomem_valid_o(iomem_valid_o), .iomem_ready_i(iomem_ready_i),
        .iomem_wstrb_o(iomem_wstrb_o), .iomem_addr_o(iomem_addr_o),
        .iomem_wdata_o(iomem_wdata_o), .iomem_rdata_i(iomem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    int          streak = 0;
    logic [31:0] last_ins = 32'h0;
    logic [31:0] last_dat = 32'h0;
    logic [31:0] mem [logic [31:0]];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic slot();
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    task automatic ram_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
        logic [31:0] v;
        v = ram_rd(a);
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = w[8*b +: 8];
        mem[a] = v;
    endtask

    function automatic logic [31:0] ram_addr();
        return 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // One arbitration + bus transaction, starting in a slot where the DUT is idle.
    task automatic txn(input bit ins_on, input bit dat_on, input logic [31:0] ia,
                       input logic [31:0] da, input logic [3:0] ws, input logic [31:0] wd,
                       input int ram_delay, output bit won_dat);
        bit          exp_dat;
        bit          done;
        bit          ok;
        int          delay;
        int          k;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
        logic [31:0] resp;
        logic [31:0] exp_rd;

        ins_req_i   = ins_on;
        ins_addr_i  = ia;
        dat_req_i   = dat_on;
        dat_addr_i  = da;
        dat_wstrb_i = ws;
        dat_wdata_i = wd;
        #1;
        exp_dat = dat_on && !(ins_on && streak == DATA_PRIO_MAX);
        chk1("busy_idle", busy_o, 1'b0);
        chk1("dat_gnt", dat_gnt_o, exp_dat);
        chk1("ins_gnt", ins_gnt_o, !exp_dat);
        if (exp_dat) streak = ins_on ? ((streak < DATA_PRIO_MAX) ? streak + 1 : streak) : 0;
        else streak = 0;
        won_dat = exp_dat;

        a = exp_dat ? da : ia;
        s = exp_dat ? ws : 4'h0;
        w = exp_dat ? wd : 32'h0;
        case (a[31:28])
            4'h3:    delay = 0;
            4'h4:    delay = ram_delay;
            default: delay = -1;
        endcase

        slot();
        if (exp_dat) dat_req_i = 1'b0;
        else ins_req_i = 1'b0;
        chk32("bus_addr", iomem_addr_o, a);
        chk32("bus_wstrb", {28'h0, iomem_wstrb_o}, {28'h0, s});
        chk32("bus_wdata", iomem_wdata_o, w);
        chk1("ins_gnt_busy", ins_gnt_o, 1'b0);
        chk1("dat_gnt_busy", dat_gnt_o, 1'b0);
        chk1("ins_rvalid_clr", ins_rvalid_o, 1'b0);
        chk1("dat_rvalid_clr", dat_rvalid_o, 1'b0);

        done = 0; ok = 0; k = 0; exp_rd = 32'h0;
        while (!done) begin
            chk1("valid_busy", iomem_valid_o, 1'b1);
            if (k == delay) begin
                resp = (a[31:28] == 4'h3) ? $urandom : ram_rd(a);
                iomem_ready_i = 1'b1;
                iomem_rdata_i = (s != 4'h0) ? $urandom : resp;
                exp_rd = (s != 4'h0) ? 32'h0 : resp;
                if (s != 4'h0 && a[31:28] == 4'h4) ram_wr(a, s, w);
                ok = 1; done = 1;
            end else begin
                iomem_rdata_i = $urandom;
                if (k == TIMEOUT_CYCLES - 1) done = 1;
            end
            k++;
            slot();
            iomem_ready_i = 1'b0;
        end
        if (!ok) chk32("valid_cycles", 32'(k), 32'(TIMEOUT_CYCLES));

        chk1("valid_after", iomem_valid_o, 1'b0);
        chk1("busy_after", busy_o, 1'b0);
        if (exp_dat) begin
            chk1("dat_rvalid", dat_rvalid_o, 1'b1);
            chk1("dat_err", dat_err_o, !ok);
            chk32("dat_rdata", dat_rdata_o, exp_rd);
            chk1("ins_rvalid_other", ins_rvalid_o, 1'b0);
            chk1("ins_err_other", ins_err_o, 1'b0);
            chk32("ins_rdata_hold", ins_rdata_o, last_ins);
            last_dat = exp_rd;
        end else begin
            chk1("ins_rvalid", ins_rvalid_o, 1'b1);
            chk1("ins_err", ins_err_o, !ok);
            chk32("ins_rdata", ins_rdata_o, exp_rd);
            chk1("dat_rvalid_other", dat_rvalid_o, 1'b0);
            chk1("dat_err_other", dat_err_o, 1'b0);
            chk32("dat_rdata_hold", dat_rdata_o, last_dat);
            last_ins = exp_rd;
        end
    endtask

    initial begin
        bit          wd;
        bit          p_ins;
        bit          p_dat;
        logic [31:0] p_ia;
        logic [31:0] p_da;
        logic [3:0]  p_ws;
        logic [31:0] p_wd;
        string       seq;
        string       exp_seq;
        int          r;

        for (int i = 0; i < 16; i++) mem[32'h4000_0000 + 32'(i * 4)] = $urandom;
        mem[32'h4000_0000] = 32'h0000_0013;

        rst_n = 1'b0;
        ins_req_i = 1'b0; ins_addr_i = 32'h0;
        dat_req_i = 1'b0; dat_addr_i = 32'h0; dat_wstrb_i = 4'h0; dat_wdata_i = 32'h0;
        iomem_ready_i = 1'b0; iomem_rdata_i = 32'h0;
        slot();
        slot();
        ins_req_i = 1'b1; dat_req_i = 1'b1;
        #1;
        chk1("rst_ins_gnt", ins_gnt_o, 1'b0);
        chk1("rst_dat_gnt", dat_gnt_o, 1'b0);
        slot();
        ins_req_i = 1'b0; dat_req_i = 1'b0;
        chk1("rst_valid", iomem_valid_o, 1'b0);
        chk32("rst_addr", iomem_addr_o, 32'h0);
        chk32("rst_wdata", iomem_wdata_o, 32'h0);
        chk32("rst_wstrb", {28'h0, iomem_wstrb_o}, 32'h0);
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_ins_rvalid", ins_rvalid_o, 1'b0);
        chk1("rst_dat_rvalid", dat_rvalid_o, 1'b0);
        chk1("rst_ins_err", ins_err_o, 1'b0);
        chk1("rst_dat_err", dat_err_o, 1'b0);
        chk32("rst_ins_rdata", ins_rdata_o, 32'h0);
        chk32("rst_dat_rdata", dat_rdata_o, 32'h0);
        rst_n = 1'b1;
        slot();

        // Instruction fetch from RAM, 16-cycle delay.
        txn(1, 0, 32'h4000_0000, 32'h0, 4'h0, 32'h0, 16, wd);
        // Timer read: same-cycle ready.
        txn(0, 1, 32'h0, 32'h3000_0000, 4'h0, 32'h0, 0, wd);
        // Write then read back.
        txn(0, 1, 32'h0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 5, wd);
        txn(0, 1, 32'h0, 32'h4000_0010, 4'h0, 32'h0, 3, wd);
        chk32("readback", dat_rdata_o, 32'hDEAD_BEEF);

        // Both ports requesting continuously.
        seq = "";
        for (int i = 0; i < 10; i++) begin
            txn(1, 1, 32'h4000_0020, 32'h3000_0004, 4'h0, 32'h0, 2, wd);
            seq = {seq, wd ? "D" : "I"};
        end
        exp_seq = "DDDDIDDDDI";
        n_cmp++;
        assert (seq == exp_seq) else begin
            n_err++;
            $error("FAIL grant_seq: observed %s expected %s", seq, exp_seq);
        end

        // Timeout, then ready exactly on the timeout cycle (ready wins).
        txn(0, 1, 32'h0, 32'h5000_0000, 4'h0, 32'h0, 0, wd);
        txn(0, 1, 32'h0, 32'h4000_0010, 4'h0, 32'h0, TIMEOUT_CYCLES - 1, wd);

        // Reset in the middle of a RAM read.
        ins_req_i = 1'b1; ins_addr_i = 32'h4000_0008;
        #1;
        chk1("mid_ins_gnt", ins_gnt_o, 1'b1);
        slot();
        ins_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            iomem_rdata_i = $urandom;
            slot();
        end
        chk1("mid_valid", iomem_valid_o, 1'b1);
        rst_n = 1'b0;
        slot();
        rst_n = 1'b1;
        chk1("mid_rst_valid", iomem_valid_o, 1'b0);
        chk1("mid_rst_busy", busy_o, 1'b0);
        chk32("mid_rst_addr", iomem_addr_o, 32'h0);
        chk1("mid_rst_ins_rvalid", ins_rvalid_o, 1'b0);
        chk32("mid_rst_ins_rdata", ins_rdata_o, 32'h0);
        chk32("mid_rst_dat_rdata", dat_rdata_o, 32'h0);
        streak = 0; last_ins = 32'h0; last_dat = 32'h0;
        slot();
        chk1("mid_post_ins_rvalid", ins_rvalid_o, 1'b0);
        chk1("mid_post_dat_rvalid", dat_rvalid_o, 1'b0);
        txn(1, 0, 32'h4000_0008, 32'h0, 4'h0, 32'h0, 4, wd);

        // Randomized traffic; a losing request stays pending with its payload.
        p_ins = 0; p_dat = 0;
        p_ia = 32'h0; p_da = 32'h0; p_ws = 4'h0; p_wd = 32'h0;
        for (int i = 0; i < 60; i++) begin
            if (!p_ins && $urandom_range(0, 1) == 1) begin
                p_ins = 1;
                p_ia = ($urandom_range(0, 4) == 0) ? 32'h3000_0000 : ram_addr();
            end
            if (!p_dat && ($urandom_range(0, 2) != 0 || !p_ins)) begin
                p_dat = 1;
                r = $urandom_range(0, 19);
                p_da = (r == 0) ? 32'h5000_0000 : (r < 4) ? 32'h3000_0008 : ram_addr();
                p_ws = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
                p_wd = $urandom;
            end
            txn(p_ins, p_dat, p_ia, p_da, p_ws, p_wd, $urandom_range(0, 20), wd);
            if (wd) p_dat = 0;
            else p_ins = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
